// File: rtl/mix_column_engine.sv
// mix_column_engine: iterative AES MixColumns / InvMixColumns on a 128-bit
// state. A block is accepted in IDLE, transformed COLS_PER_CYCLE columns per
// cycle in place during BUSY, then held in DONE until the consumer takes it.
module mix_column_engine #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("mix_column_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // Counter advance per BUSY cycle; for 4 columns per cycle it is 0 mod 4,
    // so the counter stays at 0 and the single BUSY cycle is also the last.
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [1:0]   col_cnt_q;
    logic         mode_q;
    logic [127:0] work_q;
    logic [127:0] work_d;
    logic         accept;
    logic         last_col;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward column mix {02,03,01,01}: each output byte is the column XOR
    // folded with the doubled sum of itself and its downward neighbour.
    function automatic logic [31:0] mix_fwd(input logic [31:0] col);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        logic [7:0] t;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        t  = a0 ^ a1 ^ a2 ^ a3;
        return {a0 ^ t ^ xtime(a0 ^ a1),
                a1 ^ t ^ xtime(a1 ^ a2),
                a2 ^ t ^ xtime(a2 ^ a3),
                a3 ^ t ^ xtime(a3 ^ a0)};
    endfunction

    // Inverse mix reuses the forward mixer: {0E,0B,0D,09} factors as
    // {02,03,01,01} x {05,00,04,00}, and the second factor is a cheap
    // pre-pass adding 4*(a0^a2) to rows 0/2 and 4*(a1^a3) to rows 1/3.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0]  u;
        logic [7:0]  v;
        logic [31:0] pre;
        u   = xtime(xtime(col[31:24] ^ col[15:8]));
        v   = xtime(xtime(col[23:16] ^ col[7:0]));
        pre = inv ? (col ^ {u, v, u, v}) : col;
        return mix_fwd(pre);
    endfunction

    assign accept   = in_valid && (state_q == IDLE);
    assign last_col = (col_cnt_q == LAST_COL);
    assign data_out = work_q;

    // Replace the columns selected by the counter; column k sits at bits
    // [127-32k : 96-32k], so its LSB offset is 96 - 32k.
    always_comb begin
        work_d = work_q;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            work_d[7'd96 - {col_cnt_q + 2'(j), 5'b0} +: 32] =
                mix_col(work_q[7'd96 - {col_cnt_q + 2'(j), 5'b0} +: 32], mode_q);
        end
    end

    // Next-state and handshake outputs; no bypass from DONE straight to BUSY.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (last_col) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Working register, latched mode and column counter; reset discards any
    // block in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q    <= '0;
            mode_q    <= 1'b0;
            col_cnt_q <= 2'd0;
        end else if (accept) begin
            work_q    <= data_in;
            mode_q    <= mode;
            col_cnt_q <= 2'd0;
        end else if (state_q == BUSY) begin
            work_q    <= work_d;
            col_cnt_q <= col_cnt_q + COL_STEP;
        end
    end

endmodule
